// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit:
// ecall FSM encoding, 2-bit counter values and the saturating step.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fsm_e;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port, one falling-edge update port. Same-index read/write shows the old value.
module bht_2bit
  import pipe_ctrl_pkg::*;
#(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] BHT_INIT = WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr [2**IDX_W];

  // NOTE: this table must be reset entry by entry so every counter starts at
  // BHT_INIT; a flop array without reset would power up to unknown predictions.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**IDX_W; i++) ctr[i] <= BHT_INIT;
    end else if (wr_en) begin
      ctr[wr_idx] <= sat_step(ctr[wr_idx], wr_taken);
    end
  end

  assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Pipeline control for the 5-stage core: mispredict redirect/flush, load-use
// stall, branch prediction via the BHT, and the ecall drain/halt sequence.
module branch_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int         IDX_W     = 4,
  parameter logic [1:0] BHT_INIT  = 2'b01,
  parameter int         DRAIN_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_pc,
  output logic        guess,
  input  logic [4:0]  d_rs1_index,
  input  logic [4:0]  d_rs2_index,
  input  logic [4:0]  e_rd_index,
  input  logic        e_wb_sel,
  input  logic        e_wb_en,
  input  logic [31:0] m_pc,
  input  logic        m_is_branch,
  input  logic        m_is_jalr,
  input  logic        m_branch_taken,
  input  logic        m_guess,
  input  logic [31:0] m_jb_addr,
  input  logic        m_ecall,
  output logic        stall_fd,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        flush_em,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        halt
);

  localparam int CNT_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  fsm_e             state;
  logic [CNT_W-1:0] drain_cnt;
  logic [1:0]       rd_ctr;
  logic             run;
  logic             mis;
  logic             lu;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{f_pc[31:IDX_W+2], f_pc[1:0]};

  bht_2bit #(
    .IDX_W    (IDX_W),
    .BHT_INIT (BHT_INIT)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (f_pc[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (m_is_branch & run),
    .wr_idx   (m_pc[IDX_W+1:2]),
    .wr_taken (m_branch_taken)
  );

  assign guess = rd_ctr[1];

  // Once draining or halted the pipe is frozen, so mispredicts are ignored.
  assign run = (state == RUN);
  assign mis = run & (m_is_jalr | (m_is_branch & (m_branch_taken ^ m_guess)));
  assign lu  = e_wb_sel & e_wb_en & (e_rd_index != 5'd0) &
               ((e_rd_index == d_rs1_index) | (e_rd_index == d_rs2_index));

  assign redirect = mis;
  assign flush_fd = mis;
  assign flush_em = mis;
  assign flush_de = mis | lu | ~run;
  assign stall_fd = ~mis & (lu | ~run);

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // the paths that skip an assignment infer a latch.
  always_comb begin
    redirect_pc = 32'd0;
    if (mis) redirect_pc = (m_is_jalr | m_branch_taken) ? m_jb_addr : m_pc + 32'd4;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs before any of them change on the edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      halt      <= 1'b0;
    end else begin
      case (state)
        RUN: if (m_ecall && !mis) begin
          state     <= DRAIN;
          drain_cnt <= CNT_W'(DRAIN_CYC - 1);
        end
        DRAIN: if (drain_cnt == '0) begin
          state <= HALT;
          halt  <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt - 1'b1;
        end
        HALT: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench: directed steps plus a randomized phase, compared against
// a behavioural model of prediction, hazards and the ecall drain sequence.
module tb_branch_hazard_ctrl;

  localparam int IDX_W     = 4;
  localparam int DRAIN_CYC = 2;

  logic        clk = 1'b1;
  logic        rst;
  logic [31:0] f_pc;
  logic        guess;
  logic [4:0]  d_rs1_index, d_rs2_index, e_rd_index;
  logic        e_wb_sel, e_wb_en;
  logic [31:0] m_pc, m_jb_addr;
  logic        m_is_branch, m_is_jalr, m_branch_taken, m_guess, m_ecall;
  logic        stall_fd, flush_fd, flush_de, flush_em, redirect, halt;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int ctr [16];
  int drain_left;
  bit halted;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.IDX_W(IDX_W), .BHT_INIT(2'b01), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .guess(guess),
    .d_rs1_index(d_rs1_index), .d_rs2_index(d_rs2_index), .e_rd_index(e_rd_index),
    .e_wb_sel(e_wb_sel), .e_wb_en(e_wb_en), .m_pc(m_pc), .m_is_branch(m_is_branch),
    .m_is_jalr(m_is_jalr), .m_branch_taken(m_branch_taken), .m_guess(m_guess),
    .m_jb_addr(m_jb_addr), .m_ecall(m_ecall), .stall_fd(stall_fd), .flush_fd(flush_fd),
    .flush_de(flush_de), .flush_em(flush_em), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ctr[i] = 1;
    drain_left = 0;
    halted     = 0;
  endtask

  function automatic bit model_running();
    return !halted && drain_left == 0;
  endfunction

  function automatic bit model_mis();
    return model_running() &&
           (m_is_jalr || (m_is_branch && (m_branch_taken != m_guess)));
  endfunction

  // Advance the model by one falling edge using the inputs held before it.
  task automatic model_edge();
    int idx;
    bit mis;
    mis = model_mis();
    idx = (m_pc / 4) % 16;
    if (model_running() && m_is_branch) begin
      if (m_branch_taken) ctr[idx] = (ctr[idx] < 3) ? ctr[idx] + 1 : 3;
      else                ctr[idx] = (ctr[idx] > 0) ? ctr[idx] - 1 : 0;
    end
    if (model_running() && m_ecall && !mis) begin
      drain_left = DRAIN_CYC;
    end else if (drain_left > 0) begin
      drain_left--;
      if (drain_left == 0) halted = 1;
    end
  endtask

  task automatic check_all(input string tag);
    bit mis, lu, run;
    logic [31:0] exp_pc;
    run = model_running();
    mis = model_mis();
    lu  = e_wb_sel && e_wb_en && e_rd_index != 0 &&
          (e_rd_index == d_rs1_index || e_rd_index == d_rs2_index);
    exp_pc = 32'd0;
    if (mis) exp_pc = (m_is_jalr || m_branch_taken) ? m_jb_addr : m_pc + 32'd4;
    check({tag, ".guess"},       guess,       32'(ctr[(f_pc / 4) % 16] >= 2));
    check({tag, ".redirect"},    redirect,    32'(mis));
    check({tag, ".redirect_pc"}, redirect_pc, exp_pc);
    check({tag, ".flush_fd"},    flush_fd,    32'(mis));
    check({tag, ".flush_em"},    flush_em,    32'(mis));
    check({tag, ".flush_de"},    flush_de,    32'(mis || lu || !run));
    check({tag, ".stall_fd"},    stall_fd,    32'(!mis && (lu || !run)));
    check({tag, ".halt"},        halt,        32'(halted));
  endtask

  task automatic clear_inputs();
    f_pc = 0; d_rs1_index = 0; d_rs2_index = 0; e_rd_index = 0;
    e_wb_sel = 0; e_wb_en = 0; m_pc = 0; m_jb_addr = 0;
    m_is_branch = 0; m_is_jalr = 0; m_branch_taken = 0; m_guess = 0; m_ecall = 0;
  endtask

  task automatic tick();
    if (rst) model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic branch(input logic [31:0] pc, input bit taken, input bit g,
                        input logic [31:0] tgt);
    clear_inputs();
    m_is_branch = 1; m_pc = pc; m_branch_taken = taken; m_guess = g; m_jb_addr = tgt;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    check_all("reset");
    check("reset_guess", guess, 32'd0);
    tick();
    rst = 1'b1;
    #1;

    // Train index 0 up: taken twice, first mispredicted, second correct.
    branch(32'h0, 1, 0, 32'h200);
    check_all("tk1");
    check("tk1_redirect", redirect, 32'd1);
    check("tk1_target", redirect_pc, 32'h200);
    tick();
    branch(32'h0, 1, 1, 32'h200);
    check_all("tk2");
    check("tk2_no_redirect", redirect, 32'd0);
    tick();
    clear_inputs(); f_pc = 32'h40; #1;
    check("alias_guess", guess, 32'd1);

    // Walk index 0 down and past the floor.
    branch(32'h100, 0, 1, 32'h300);
    check_all("nt1");
    check("nt1_fallthrough", redirect_pc, 32'h104);
    tick();
    for (int i = 0; i < 3; i++) begin
      branch(32'h100, 0, 0, 32'h300);
      check_all("nt_walk");
      tick();
    end
    branch(32'h0, 1, 0, 32'h80);
    check_all("floor_tk");
    tick();
    clear_inputs(); #1;
    check("floor_guess", guess, 32'd0);

    // Fall-through address wraps at the top of the address space.
    branch(32'hFFFF_FFFC, 0, 1, 32'h10);
    check("wrap_pc", redirect_pc, 32'h0);
    check_all("wrap");
    tick();

    // Load-use hazard.
    clear_inputs(); e_wb_sel = 1; e_wb_en = 1; e_rd_index = 5; d_rs1_index = 5; #1;
    check("lu_stall", stall_fd, 32'd1);
    check("lu_flush_de", flush_de, 32'd1);
    check("lu_flush_fd", flush_fd, 32'd0);
    check_all("lu_rs1");
    tick();
    e_rd_index = 0; d_rs1_index = 0; #1;
    check("lu_x0_stall", stall_fd, 32'd0);
    check_all("lu_x0");
    e_rd_index = 9; d_rs2_index = 9; #1;
    check_all("lu_rs2");
    tick();

    // Load-use and jalr together: redirect wins.
    e_rd_index = 7; d_rs1_index = 7; m_is_jalr = 1; m_jb_addr = 32'h1234; #1;
    check("lujr_stall", stall_fd, 32'd0);
    check("lujr_redirect_pc", redirect_pc, 32'h1234);
    check("lujr_flush_em", flush_em, 32'd1);
    check_all("lujr");
    tick();

    // Randomized phase without ecall.
    for (int n = 0; n < 400; n++) begin
      f_pc           = $urandom;
      d_rs1_index    = 5'($urandom_range(0, 3));
      d_rs2_index    = 5'($urandom_range(0, 3));
      e_rd_index     = 5'($urandom_range(0, 3));
      e_wb_sel       = 1'($urandom_range(0, 1));
      e_wb_en        = 1'($urandom_range(0, 1));
      m_pc           = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      m_jb_addr      = $urandom;
      m_is_branch    = 1'($urandom_range(0, 1));
      m_is_jalr      = ($urandom_range(0, 7) == 0);
      m_branch_taken = 1'($urandom_range(0, 1));
      m_guess        = 1'($urandom_range(0, 1));
      m_ecall        = 1'b0;
      #1;
      check_all("rand");
      tick();
    end

    // Ecall together with a mispredict is not accepted.
    clear_inputs(); m_ecall = 1; m_is_jalr = 1; m_jb_addr = 32'h40; #1;
    check_all("ecall_mis");
    tick();
    clear_inputs(); #1;
    check("ecall_mis_no_drain", stall_fd, 32'd0);

    // Ecall drain then halt; mispredicts ignored while halted.
    m_ecall = 1; #1;
    check_all("ecall");
    tick();
    clear_inputs(); #1;
    for (int i = 0; i < DRAIN_CYC; i++) begin
      check("drain_stall", stall_fd, 32'd1);
      check("drain_halt", halt, 32'd0);
      check_all("drain");
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      m_is_branch = 1; m_branch_taken = 1; m_guess = 0; m_is_jalr = 1'(i % 2);
      m_jb_addr = 32'h500; #1;
      check("halt_held", halt, 32'd1);
      check("halt_no_redirect", redirect, 32'd0);
      check_all("halted");
      tick();
    end

    // Reset out of HALT.
    clear_inputs(); rst = 1'b0; model_reset(); #1;
    check_all("rst_halt");
    tick();
    rst = 1'b1; #1;

    // Train index 5 to strongly taken, enter DRAIN, reset asynchronously mid-cycle.
    branch(32'h14, 1, 0, 32'h0); tick();
    branch(32'h14, 1, 1, 32'h0); tick();
    clear_inputs(); f_pc = 32'h14; #1;
    check("train5_guess", guess, 32'd1);
    m_ecall = 1; #1;
    tick();
    m_ecall = 0; #1;
    check("mid_drain_stall", stall_fd, 32'd1);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_rst_halt", halt, 32'd0);
    check("async_rst_stall", stall_fd, 32'd0);
    check("async_rst_guess", guess, 32'd0);
    check_all("async_rst");
    tick();
    rst = 1'b1; #1;
    check_all("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RISC-V core.
- Produces the stall and flush strobes that drive the F/D, D/E and E/M pipeline registers, and the fetch redirect.
- Owns a 2-bit saturating branch history table (BHT) that supplies the `guess` bit carried down the pipe.
- Runs an ecall drain/halt state machine.

Parameters:
- IDX_W, 4, BHT index width; table holds 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- BHT_INIT, 2'b01, counter value after reset (weakly not-taken).
- DRAIN_CYC, 2, cycles spent in DRAIN after an ecall reaches M, before HALT.

Ports:
- clk  in  1  pipeline clock; all state updates on falling edge, same edge as pipeline registers.
- rst  in  1  asynchronous active-low reset.
- f_pc  in  32  fetch-stage PC, used for BHT lookup.
- guess  out  1  predicted-taken for f_pc.
- d_rs1_index  in  5  D-stage source 1 index.
- d_rs2_index  in  5  D-stage source 2 index.
- e_rd_index  in  5  E-stage destination index.
- e_wb_sel  in  1  E-stage instruction is a load (1 = write back from data memory).
- e_wb_en  in  1  E-stage register write enable.
- m_pc  in  32  M-stage PC.
- m_is_branch  in  1  M-stage conditional branch valid.
- m_is_jalr  in  1  M-stage jalr valid.
- m_branch_taken  in  1  actual branch outcome.
- m_guess  in  1  prediction carried with the M-stage instruction.
- m_jb_addr  in  32  computed jump/branch target.
- m_ecall  in  1  M-stage ecall valid.
- stall_fd  out  1  hold PC and F/D register.
- flush_fd  out  1  squash F/D register.
- flush_de  out  1  squash D/E register (insert bubble).
- flush_em  out  1  squash E/M control fields.
- redirect  out  1  load redirect_pc into PC.
- redirect_pc  out  32  corrected fetch address.
- halt  out  1  core halted after ecall, sticky.

Behaviour:
- State is BHT counters[2**IDX_W] plus FSM {RUN, DRAIN, HALT} plus drain counter.
- Reset (async, rst=0):
  - every counter = BHT_INIT, FSM = RUN, drain counter = 0.
  - Resulting outputs: halt=0; stall/flush/redirect all 0 provided the M/E inputs are inactive; guess = BHT_INIT[1].
- Reset mid-DRAIN or in HALT returns to RUN immediately.
- Prediction (combinational):
  - guess = counters[f_pc[IDX_W+1:2]][1].
  - On a same-edge read/write to the same index, guess shows the pre-update value.
- BHT update, falling edge, when m_is_branch=1 and FSM=RUN:
  - taken: counter increments, saturating at 3.
  - not taken: counter decrements, saturating at 0.
  - jalr does not update.
- Mispredict (combinational): mis = m_is_jalr | (m_is_branch & (m_branch_taken ^ m_guess)).
  - Outputs when mis=1: redirect=1, flush_fd=1, flush_de=1, flush_em=1.
  - redirect_pc = m_jb_addr if (m_is_jalr | m_branch_taken), else m_pc+4 (32-bit wrap).
  - redirect_pc = 0 when redirect=0.
- Load-use (combinational):
  - lu = e_wb_sel & e_wb_en & (e_rd_index != 0) & (e_rd_index == d_rs1_index | e_rd_index == d_rs2_index).
  - Outputs: stall_fd=1, flush_de=1 for exactly that cycle.
- Priority:
  - mis overrides lu; stall_fd=0 when mis=1, because the redirect wins.
  - Both asserted in the same cycle -> mis outputs only.
- Ecall FSM:
  - RUN -> DRAIN on a falling edge with m_ecall=1 and mis=0; the drain counter loads DRAIN_CYC-1.
  - DRAIN: stall_fd=1, flush_de=1; counter decrements each edge; -> HALT when the counter is 0 at the edge.
  - HALT: stall_fd=1, flush_de=1, halt=1; remains until reset.
  - mis is ignored in DRAIN and HALT: redirect=0, no BHT update.
- No combinational path from any output back to an input inside the block.

Decomposition:
- Shared package (pipe_ctrl_pkg):
  - FSM state encoding RUN=2'd0, DRAIN=2'd1, HALT=2'd2.
  - 2-bit counter constants SNT=0, WNT=1, WT=2, ST=3.
- Sub-module bht_2bit (parameter IDX_W, BHT_INIT):
  - one combinational read port.
  - one falling-edge saturating-update port with enable.
  - async active-low reset.

Test Plan:
- Reset, f_pc=0x00 -> guess=0. Two taken branches at m_pc=0x00, m_guess=0: first -> redirect=1 to m_jb_addr, counter 1->2; second, m_guess=1 -> no redirect, counter 2->3; then f_pc=0x40 (same index, IDX_W=4) -> guess=1.
- Counter at 3, three not-taken branches -> counter 3->2->1->0 then saturates at 0; the first not-taken with m_guess=1 gives redirect_pc=m_pc+4=0x104 for m_pc=0x100.
- e_wb_sel=1, e_wb_en=1, e_rd_index=5, d_rs1_index=5 -> stall_fd=1, flush_de=1, flush_fd=0; repeat with e_rd_index=0 -> no stall.
- Load-use and m_is_jalr=1 in the same cycle -> stall_fd=0, redirect=1, redirect_pc=m_jb_addr, all three flushes=1.
- m_ecall pulse -> DRAIN for 2 edges (stall_fd=flush_de=1, halt=0), then halt=1 held for 10+ cycles; a mispredict input while in HALT -> redirect stays 0.
- Assert rst low asynchronously mid-DRAIN and mid-cycle -> halt=0 and FSM=RUN without waiting for a clock edge; all counters return to BHT_INIT.
